// File: rtl/led_pkg.sv
// Shared encodings and helpers for the LED pattern engine.
//   mode_e     : pattern select encodings (SHIFT, FILL_EMPTY, PINGPONG, BLINK)
//   phase_e    : direction phase for FILL_EMPTY / PINGPONG
//   init_value : first LED image shown after a load, for a given mode/dir/width
package led_pkg;

    localparam int unsigned MAX_LED = 32;

    typedef enum logic [1:0] {
        MODE_SHIFT = 2'd0,
        MODE_FILL  = 2'd1,
        MODE_PING  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    typedef enum logic {
        PH_UP   = 1'b0,
        PH_DOWN = 1'b1
    } phase_e;

    // Returned at full 32-bit width; the caller truncates to its LED count.
    function automatic logic [MAX_LED-1:0] init_value(
        input mode_e       m,
        input logic        d,
        input int unsigned n
    );
        logic [MAX_LED-1:0] v;
        v = MAX_LED'(1);
        case (m)
            MODE_SHIFT: v = d ? (MAX_LED'(1) << (n - 1)) : MAX_LED'(1);
            MODE_BLINK: v = '1;
            default:    v = MAX_LED'(1);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle clock enable every DIV clocks while run=1.
//   clk_50M : board clock
//   reset   : synchronous active-low reset
//   run     : 1 = count, 0 = hold count and suppress tick
//   tick    : combinational enable, high in the cycle where count==DIV-1 and run=1
module tick_gen #(
    parameter int unsigned DIV = 12_500_000
) (
    input  logic clk_50M,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_wrap;

    assign w_wrap = (r_count == LAST);
    assign tick   = run && w_wrap;

    // Free-running modulo-DIV counter, frozen while run is low.
    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= w_wrap ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern generator: drives an N_LED bank with one of four patterns,
// advancing one step per prescaler tick.
//   clk_50M   : board clock
//   reset     : synchronous active-low reset
//   run       : 1 = advance, 0 = freeze outputs and prescaler
//   mode      : 0 SHIFT, 1 FILL_EMPTY, 2 PINGPONG, 3 BLINK (sampled on ticks)
//   dir       : SHIFT direction, 0 toward MSB, 1 toward LSB (sampled on ticks)
//   out       : registered LED drive
//   step_tick : registered pulse in the cycle following each out update
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int unsigned N_LED = 8,
    parameter int unsigned DIV   = 12_500_000
) (
    input  logic             clk_50M,
    input  logic             reset,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [N_LED-1:0] out,
    output logic             step_tick
);

    localparam logic [N_LED-1:0] ALL_ON = '1;
    localparam logic [N_LED-1:0] ONE    = N_LED'(1);

    logic             w_tick;
    mode_e            w_mode_sel;
    logic [N_LED-1:0] w_init;
    logic             w_onehot;

    logic [N_LED-1:0] r_out,          w_out_nxt;
    phase_e           r_phase,        w_phase_nxt;
    mode_e            r_mode_q,       w_mode_q_nxt;
    logic             r_load_pending, w_load_nxt;
    logic             r_step_tick;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk_50M (clk_50M),
        .reset   (reset),
        .run     (run),
        .tick    (w_tick)
    );

    assign w_mode_sel = mode_e'(mode);
    assign w_init     = N_LED'(init_value(w_mode_sel, dir, N_LED));
    // Single-lit check used to recover SHIFT/PINGPONG from corrupted images.
    assign w_onehot   = (r_out != '0) && ((r_out & (r_out - ONE)) == '0);

    // State register.
    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            r_out          <= '0;
            r_phase        <= PH_UP;
            r_mode_q       <= MODE_SHIFT;
            r_load_pending <= 1'b1;
            r_step_tick    <= 1'b0;
        end else begin
            r_out          <= w_out_nxt;
            r_phase        <= w_phase_nxt;
            r_mode_q       <= w_mode_q_nxt;
            r_load_pending <= w_load_nxt;
            r_step_tick    <= w_tick;
        end
    end

    // Next-state: only tick cycles change the pattern.
    always_comb begin
        w_out_nxt    = r_out;
        w_phase_nxt  = r_phase;
        w_mode_q_nxt = r_mode_q;
        w_load_nxt   = r_load_pending;

        if (w_tick) begin
            if (r_load_pending || (w_mode_sel != r_mode_q)) begin
                // New mode shows its initial image on this same edge.
                w_mode_q_nxt = w_mode_sel;
                w_out_nxt    = w_init;
                w_phase_nxt  = PH_UP;
                w_load_nxt   = 1'b0;
            end else begin
                case (r_mode_q)
                    MODE_SHIFT: begin
                        if (!w_onehot) begin
                            w_out_nxt = w_init;
                        end else if (dir) begin
                            w_out_nxt = {r_out[0], r_out[N_LED-1:1]};
                        end else begin
                            w_out_nxt = {r_out[N_LED-2:0], r_out[N_LED-1]};
                        end
                    end
                    MODE_FILL: begin
                        if (r_phase == PH_UP) begin
                            if (r_out == ALL_ON) begin
                                w_phase_nxt = PH_DOWN;
                                w_out_nxt   = r_out << 1;
                            end else begin
                                w_out_nxt   = (r_out << 1) | ONE;
                            end
                        end else begin
                            if (r_out == '0) begin
                                w_phase_nxt = PH_UP;
                                w_out_nxt   = ONE;
                            end else begin
                                w_out_nxt   = r_out << 1;
                            end
                        end
                    end
                    MODE_PING: begin
                        // Phase flips on the step that lands on an end LED,
                        // so each end is shown exactly once per bounce.
                        if (!w_onehot) begin
                            w_out_nxt   = ONE;
                            w_phase_nxt = PH_UP;
                        end else if (r_phase == PH_UP && !r_out[N_LED-1]) begin
                            w_out_nxt = r_out << 1;
                            if (r_out[N_LED-2]) begin
                                w_phase_nxt = PH_DOWN;
                            end
                        end else if (r_phase == PH_DOWN && !r_out[0]) begin
                            w_out_nxt = r_out >> 1;
                            if (r_out[1]) begin
                                w_phase_nxt = PH_UP;
                            end
                        end else begin
                            // Phase disagrees with position: bounce off the end.
                            w_out_nxt   = r_out[0] ? (r_out << 1) : (r_out >> 1);
                            w_phase_nxt = r_out[0] ? PH_UP : PH_DOWN;
                        end
                    end
                    MODE_BLINK: begin
                        if ((r_out == '0) || (r_out == ALL_ON)) begin
                            w_out_nxt = ~r_out;
                        end else begin
                            w_out_nxt = ALL_ON;
                        end
                    end
                    default: begin
                        w_out_nxt = w_init;
                    end
                endcase
            end
        end
    end

    assign out       = r_out;
    assign step_tick = r_step_tick;

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
Parametrised LED pattern generator for the 50 MHz board clock. Drives an N-bit LED bank with one of four runtime-selectable patterns (walking shift, fill-then-empty, ping-pong, blink). Step rate is set by a prescaler producing a one-cycle clock enable, not a derived clock. Sits directly under the board top level, between clock/reset and the LED pins.

Parameters:
N_LED, 8, number of LEDs; legal range 2..32.
DIV, 12_500_000, board clocks per pattern step (4 Hz at 50 MHz); minimum 2.
CNT_W, $clog2(DIV), prescaler width (derived, not overridden).

Ports:
clk_50M  input  1  board clock, 50 MHz; all logic on rising edge.
reset  input  1  synchronous, active-low reset (reset==0 resets on next clk_50M edge).
run  input  1  1 = prescaler and pattern advance; 0 = freeze everything (hold out, hold count).
mode  input  2  pattern select: 0 SHIFT, 1 FILL_EMPTY, 2 PINGPONG, 3 BLINK.
dir  input  1  SHIFT direction: 0 = toward MSB, 1 = toward LSB; ignored in other modes.
out  output  N_LED  LED drive, registered.
step_tick  output  1  registered one-cycle pulse, high in the cycle after each out update.

Behaviour:
- Reset (reset==0 at an edge): out=0, step_tick=0, prescaler=0, mode_q=0, phase=UP, load_pending=1. Reset mid-pattern discards all state; no partial step.
- Prescaler: when run=1, count increments; at count==DIV-1 it wraps to 0 and asserts internal tick that same cycle. run=0 holds count; no tick.
- Step period: exactly DIV clocks between out updates while run=1. step_tick=1 in the cycle after the edge that updates out.
- Mode latching: mode and dir sampled only on tick edges. mode != mode_q at a tick -> mode_q<=mode and out loads the new mode's initial value on that same edge (no intermediate step). Mode changes between ticks have no effect until the next tick; multiple changes between ticks -> last value wins.
- load_pending=1 at a tick: load initial value for mode, clear load_pending.
- Initial values: SHIFT dir0 = 1, dir1 = 1<<(N_LED-1); FILL_EMPTY = 1 (phase UP); PINGPONG = 1 (phase UP); BLINK = all ones.
- SHIFT: rotate one position per tick, direction per dir sampled at that tick; MSB wraps to LSB (dir0), LSB to MSB (dir1). dir change mid-pattern reverses from current position, no reload.
- FILL_EMPTY: phase UP: out<=(out<<1)|1 until all ones; next tick enters phase DOWN: out<=out<<1 (LEDs extinguish from LSB) until 0; next tick phase UP, out<=1. Period 2*N_LED steps; N=8 sequence 01,03,...,FF,FE,FC,...,80,00,01.
- PINGPONG: single lit LED; UP shifts left, reaching bit N_LED-1 flips phase to DOWN; DOWN shifts right, reaching bit 0 flips to UP. End LEDs shown once per bounce; period 2*N_LED-2.
- BLINK: out<=~out each tick (all on / all off).
- Illegal states (e.g. out=0 in SHIFT/PINGPONG from glitch): next tick reloads initial value.
- Simultaneous run 1->0 on a tick cycle: tick at that edge still takes effect (run sampled the same edge as count).

Decomposition:
- Package led_pkg: mode encodings (MODE_SHIFT=0, MODE_FILL=1, MODE_PING=2, MODE_BLINK=3), phase encoding (UP/DOWN), initial-value function per mode.
- Sub-module tick_gen (parameter DIV; ports clk_50M, reset, run, tick): prescaler producing the clock enable; replaces derived-clock dividers for new blocks.

Test Plan:
- N_LED=8, DIV=4, mode=0, dir=0, run=1 after reset release -> out 00 until first tick, then 01,02,04,...,80,01 every 4 clocks; step_tick one cycle after each update.
- mode=1 -> 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00,01; 16-step period.
- mode=2 -> 01,02,...,80,40,...,02,01,02; 14-step period, no repeated 80 or 01.
- mode 0->3 asserted 1 clock after a tick -> out unchanged for 3 more clocks, then FF at next tick, then 00, FF.
- run=0 for 10 clocks mid-SHIFT at out=08 -> out holds 08, no step_tick; after run=1 next update exactly (4 - count at freeze) clocks later.
- reset=0 for 1 clock while out=3F in FILL_EMPTY -> out=00, step_tick=0 next cycle; first tick after release loads 01.
